// File: rtl/gray_pkg.sv
// Shared types and gray/binary conversions for the gray run controller slice.
// Conversions work on a wide zero-extended vector, so callers cast to their own width N.
package gray_pkg;

  localparam int GRAY_MAXW = 32;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
    logic [GRAY_MAXW-1:0] b;
    b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
    for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step_core.sv
// Binary up/down register with a registered gray copy and a registered wrap pulse.
// The gray copy is loaded and stepped together with the binary value, so it never glitches.
module gray_step_core
  import gray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [N-1:0] load_bin,
  input  logic         step,
  input  logic         dir,
  output logic [N-1:0] gray,
  output logic         wrap
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] bin_reg;
  logic [N-1:0] bin_next;
  logic         crossing;

  always_comb begin
    bin_next = dir ? (bin_reg + ONE) : (bin_reg - ONE);
    crossing = dir ? (&bin_reg) : ~(|bin_reg);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin_reg <= '0;
      gray    <= '0;
      wrap    <= 1'b0;
    end else if (load) begin
      bin_reg <= load_bin;
      gray    <= N'(bin2gray(GRAY_MAXW'(load_bin)));
      wrap    <= 1'b0;
    end else if (step) begin
      bin_reg <= bin_next;
      gray    <= N'(bin2gray(GRAY_MAXW'(bin_next)));
      wrap    <= crossing;
    end else begin
      wrap    <= 1'b0;
    end
  end

endmodule

// File: rtl/gray_run_ctrl.sv
// Run sequencer: accepts {start, length, direction} requests and steps a gray counter.
// The start value is captured at the handshake and pushed into the step core during LOAD.
module gray_run_ctrl
  import gray_pkg::*;
#(
  parameter int N = 4,
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] start_gray,
  input  logic [L-1:0] run_len,
  input  logic         dir,
  input  logic         pause,
  input  logic         abort,
  output logic [N-1:0] out,
  output logic         out_valid,
  output logic         busy,
  output logic         done,
  output logic         wrap
);

  state_t       state_reg;
  logic [N-1:0] start_reg;
  logic [L-1:0] remaining_reg;
  logic         dir_reg;
  logic         out_valid_reg;
  logic         done_reg;

  logic         core_load;
  logic         core_step;
  logic [N-1:0] start_bin;

  // Abort wins over both loading and stepping, so out holds its last value.
  assign core_load = (state_reg == LOAD) && !abort;
  assign core_step = (state_reg == RUN) && !pause && !abort;
  assign start_bin = N'(gray2bin(GRAY_MAXW'(start_reg)));

  gray_step_core #(
    .N (N)
  ) u_core (
    .clk      (clk),
    .rstn     (rstn),
    .load     (core_load),
    .load_bin (start_bin),
    .step     (core_step),
    .dir      (dir_reg),
    .gray     (out),
    .wrap     (wrap)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      start_reg     <= '0;
      remaining_reg <= '0;
      dir_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_valid) begin
            start_reg     <= start_gray;
            remaining_reg <= run_len;
            dir_reg       <= dir;
            state_reg     <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            out_valid_reg <= 1'b1;
            state_reg     <= (remaining_reg != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (abort) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end else if (!pause) begin
            remaining_reg <= remaining_reg - L'(1);
            if (remaining_reg == L'(1)) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          if (abort) begin
            out_valid_reg <= 1'b0;
          end else begin
            done_reg <= 1'b1;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign out_valid   = out_valid_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Directed bench for gray_run_ctrl: run-level reference model checked every cycle,
// plus hand-computed output sequences for each directed run.
module tb_gray_run_ctrl;

  localparam int N = 4;
  localparam int L = 8;
  localparam int MODV = 1 << N;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start_valid = 1'b0;
  logic [N-1:0] start_gray = '0;
  logic [L-1:0] run_len = '0;
  logic         dir = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic         start_ready;
  logic [N-1:0] out;
  logic         out_valid;
  logic         busy;
  logic         done;
  logic         wrap;

  gray_run_ctrl #(.N(N), .L(L)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_gray  (start_gray),
    .run_len     (run_len),
    .dir         (dir),
    .pause       (pause),
    .abort       (abort),
    .out         (out),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gray to binary as the XOR of all right shifts of the code word.
  function automatic int g2b(input int g);
    int b;
    b = 0;
    for (int s = 0; s < N; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Run-level model: a run emits its start value, then value i = start + i*dir (mod 2^N).
  bit m_busy, m_valid, m_done, m_wrap, m_step, m_dir;
  int m_out, m_idx, m_len, m_sb, m_start;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_wrap = 0; m_step = 0;
      m_out = 0; m_idx = -1; m_len = 0; m_sb = 0; m_start = 0; m_dir = 0;
    end else begin
      m_done = 0; m_wrap = 0; m_step = 0;
      if (!m_busy) begin
        if (start_valid) begin
          m_busy = 1; m_idx = -1; m_len = int'(run_len); m_dir = dir;
          m_start = int'(start_gray); m_sb = g2b(m_start);
        end
      end else if (abort) begin
        m_busy = 0; m_valid = 0;
      end else if (m_idx < 0) begin
        m_idx = 0; m_out = m_start; m_valid = 1;
      end else if (m_idx < m_len) begin
        if (!pause) begin
          int b;
          m_idx++;
          b = ((m_sb + (m_dir ? m_idx : -m_idx)) % MODV + MODV) % MODV;
          m_out = b ^ (b >> 1);
          m_wrap = m_dir ? (b == 0) : (b == MODV - 1);
          m_step = 1;
        end
      end else begin
        m_busy = 0; m_done = 1;
      end
    end
  end

  logic [N-1:0] prev_out = '0;

  always @(negedge clk) begin
    if (rstn) begin
      check("out", out, m_out);
      check("out_valid", out_valid, m_valid);
      check("busy", busy, m_busy);
      check("start_ready", start_ready, !m_busy);
      check("done", done, m_done);
      check("wrap", wrap, m_wrap);
      if (m_step) check("one_bit_flip", $countones(out ^ prev_out), 1);
    end
    prev_out = out;
  end

  int q[$];
  int wraps[$];
  int exp_q[$];
  int busy_cycles;
  bit done_seen;

  task automatic run_collect(input logic [N-1:0] g, input logic [L-1:0] len, input logic d,
                             input int pause_at, input int abort_at, input int spam_at);
    int pause_cnt;
    bit finished;
    @(posedge clk); #1;
    start_valid = 1'b1; start_gray = g; run_len = len; dir = d;
    @(posedge clk); #1;
    start_valid = 1'b0;
    q.delete(); wraps.delete();
    busy_cycles = 0; done_seen = 0; pause_cnt = -1; finished = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (wrap) wraps.push_back(int'(out));
      if (!busy) begin
        done_seen = done; finished = 1;
        break;
      end
      busy_cycles++;
      if (busy_cycles >= 2) q.push_back(int'(out));
      if (pause_cnt >= 0 && pause) begin
        pause_cnt++;
        if (pause_cnt == 3) pause = 1'b0;
      end
      if (q.size() == pause_at && pause_cnt < 0) begin
        pause = 1'b1; pause_cnt = 0;
      end
      if (abort) abort = 1'b0;
      if (q.size() == abort_at) abort = 1'b1;
      if (start_valid) start_valid = 1'b0;
      if (q.size() == spam_at) begin
        start_valid = 1'b1; start_gray = ~g; run_len = 3; dir = ~d;
        check("start_ready_while_busy", start_ready, 0);
      end
    end
    if (!finished) check("run_timeout", 0, 1);
    pause = 1'b0; abort = 1'b0; start_valid = 1'b0;
  endtask

  task automatic check_seq(input string name);
    check({name, "_len"}, q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q.size(); i++) check(name, q[i], exp_q[i]);
  endtask

  initial begin
    #2;
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_start_ready", start_ready, 1);
    check("rst_done", done, 0);
    #10 rstn = 1'b1;

    run_collect(4'h0, 8'd5, 1'b1, -1, -1, -1);
    exp_q = '{0, 1, 3, 2, 6, 7}; check_seq("up_run");
    check("up_busy_cycles", busy_cycles, 7);
    check("up_done", done_seen, 1);
    check("up_wraps", wraps.size(), 0);

    run_collect(4'h8, 8'd2, 1'b1, -1, -1, -1);
    exp_q = '{8, 0, 1}; check_seq("up_wrap");
    check("up_wrap_count", wraps.size(), 1);
    if (wraps.size() > 0) check("up_wrap_at", wraps[0], 0);
    check("up_wrap_done", done_seen, 1);

    run_collect(4'h0, 8'd1, 1'b0, -1, -1, -1);
    exp_q = '{0, 8}; check_seq("down_wrap");
    check("down_wrap_count", wraps.size(), 1);
    check("down_wrap_done", done_seen, 1);

    run_collect(4'h0, 8'd5, 1'b1, 2, -1, -1);
    exp_q = '{0, 1, 1, 1, 1, 3, 2, 6, 7}; check_seq("pause_run");
    check("pause_busy_cycles", busy_cycles, 10);
    check("pause_done", done_seen, 1);

    run_collect(4'h0, 8'd5, 1'b1, -1, 3, -1);
    exp_q = '{0, 1, 3}; check_seq("abort_run");
    check("abort_done", done_seen, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_hold", out, 3);

    run_collect(4'h6, 8'd0, 1'b1, -1, -1, -1);
    exp_q = '{6}; check_seq("zero_len");
    check("zero_busy_cycles", busy_cycles, 2);
    check("zero_done", done_seen, 1);

    run_collect(4'h3, 8'd4, 1'b0, -1, -1, 2);
    exp_q = '{3, 1, 0, 8, 9}; check_seq("busy_request");
    check("busy_request_done", done_seen, 1);
    @(negedge clk);
    check("busy_request_ignored", busy, 0);

    run_collect(4'h5, 8'd40, 1'b1, -1, -1, -1);
    check("long_len", q.size(), 41);
    check("long_wraps", wraps.size(), 2);
    check("long_done", done_seen, 1);

    @(posedge clk); #1;
    start_valid = 1'b1; start_gray = 4'h0; run_len = 8'd20; dir = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst_out", out, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_start_ready", start_ready, 1);
    check("midrst_done", done, 0);
    @(negedge clk);
    rstn = 1'b1;

    run_collect(4'h0, 8'd1, 1'b1, -1, -1, -1);
    exp_q = '{0, 1}; check_seq("after_reset");
    check("after_reset_done", done_seen, 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
